// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bus of the deserializer.
// The master drives serial bits and par_ready; the slave (the deserializer) returns words.
interface deserializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ser_i;
  logic             bit_en;
  logic             sof;
  logic             par_ready;
  logic [WIDTH-1:0] par_data;
  logic             par_valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    output ser_i, bit_en, sof, par_ready,
    input  par_data, par_valid, busy, frame_err, overrun
  );

  modport slave (
    input  ser_i, bit_en, sof, par_ready,
    output par_data, par_valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/deserializer.sv
// Framed serial-to-parallel receiver with a one-deep ready/valid output register.
// Flags frame errors (sof mid-word) and overruns (completed word dropped).
module deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  deserializer_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;
  logic             complete;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], bus.ser_i};
      first   = {{(WIDTH-1){1'b0}}, bus.ser_i};
    end else begin
      shifted = {bus.ser_i, shift_q[WIDTH-1:1]};
      first   = {bus.ser_i, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.bit_en && bus.sof) begin
          shift_d = first;
          cnt_d   = CW'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.bit_en) begin
          // sof wins over completion: a sof on the last bit aborts the word.
          if (bus.sof) begin
            frame_err_d = 1'b1;
            shift_d     = first;
            cnt_d       = CW'(1);
          end else if (cnt_q == LastCnt) begin
            complete = 1'b1;
            shift_d  = shifted;
            cnt_d    = '0;
            state_d  = StIdle;
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (complete) begin
      // A word held but accepted this cycle frees the register for the new one.
      if (!valid_q || bus.par_ready) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.par_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.par_data  = data_q;
  assign bus.par_valid = valid_q;
  assign bus.busy      = (state_q == StShift);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_deserializer.sv
// Scoreboarded bench for deserializer: MSB-first and LSB-first instances see the same stream.
module tb_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  deserializer_if #(.WIDTH(8)) bm ();
  deserializer_if #(.WIDTH(8)) bl ();

  assign bl.ser_i     = bm.ser_i;
  assign bl.bit_en    = bm.bit_en;
  assign bl.sof       = bm.sof;
  assign bl.par_ready = bm.par_ready;

  deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bm));
  deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bl));

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic pv_m = 1'b0;
  logic pv_l = 1'b0;

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // Word monitor: a new word is visible when valid rises or is refilled during a handshake.
  always @(posedge clk) begin
    logic [7:0] exp;
    #2;
    if (bm.par_valid && (!pv_m || bm.par_ready)) begin
      total++;
      if (q_m.size() == 0) begin
        bad++;
        $display("FAIL word_m: got %h, no word expected", bm.par_data);
      end else begin
        exp = q_m.pop_front();
        if (bm.par_data !== exp) begin
          bad++;
          $display("FAIL word_m: got %h, expected %h", bm.par_data, exp);
        end
      end
    end
    if (bl.par_valid && (!pv_l || bl.par_ready)) begin
      total++;
      if (q_l.size() == 0) begin
        bad++;
        $display("FAIL word_l: got %h, no word expected", bl.par_data);
      end else begin
        exp = q_l.pop_front();
        if (bl.par_data !== exp) begin
          bad++;
          $display("FAIL word_l: got %h, expected %h", bl.par_data, exp);
        end
      end
    end
    pv_m = bm.par_valid;
    pv_l = bl.par_valid;
    if (bm.frame_err) fe_cnt++;
    if (bm.overrun) ov_cnt++;
  end

  // Inputs change on the falling edge; returns one falling edge later.
  task automatic drive(input logic s, input logic e, input logic f);
    bm.ser_i  = s;
    bm.bit_en = e;
    bm.sof    = f;
    @(negedge clk);
  endtask

  task automatic expect_word(input logic [7:0] w);
    q_m.push_back(w);
    q_l.push_back(rev8(w));
  endtask

  task automatic send_word(input logic [7:0] w, input bit deliver, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && deliver) expect_word(w);
      drive(w[7-i], 1'b1, i == 0);
      if (gaps && i < 7) drive(~w[7-i], 1'b0, 1'b1);
    end
  endtask

  task automatic check_queues(input string name);
    total++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: got %0d/%0d undelivered, expected 0", name, q_m.size(), q_l.size());
    end
  endtask

  task automatic test_reset();
    bm.ser_i = 1'b0; bm.bit_en = 1'b0; bm.sof = 1'b0; bm.par_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bm.par_valid, bm.busy, bm.frame_err, bm.overrun} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b, expected 0000",
               {bm.par_valid, bm.busy, bm.frame_err, bm.overrun});
    end
    total++;
    if (bm.par_data !== 8'h00 || bl.par_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got %h/%h, expected 00/00", bm.par_data, bl.par_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_msb_lsb();
    int busy_cycles = 0;
    logic [7:0] w = 8'hA6;
    bm.par_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_word(w);
      drive(w[7-i], 1'b1, i == 0);
      if (bm.busy) busy_cycles++;
    end
    total++;
    if (bm.par_valid !== 1'b1 || bm.par_data !== 8'hA6 || bl.par_data !== 8'h65) begin
      bad++;
      $display("FAIL order: got v=%b m=%h l=%h, expected v=1 m=a6 l=65",
               bm.par_valid, bm.par_data, bl.par_data);
    end
    total++;
    if (busy_cycles != 7) begin
      bad++;
      $display("FAIL busy_len: got %0d, expected 7", busy_cycles);
    end
    drive(1'b0, 1'b0, 1'b0);
    total++;
    if (bm.par_valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_len: got %b, expected 0", bm.par_valid);
    end
    check_queues("msb_lsb");
  endtask

  task automatic test_gaps();
    int fe0 = fe_cnt;
    int cycles = 0;
    bm.par_ready = 1'b1;
    expect_word(8'hA6);
    for (int i = 0; i < 8; i++) begin
      drive(bm.ser_i ^ 1'b1, 1'b0, 1'b0);
      if (i == 0) cycles = 0;
      drive(bit'(8'hA6 >> (7 - i)), 1'b1, i == 0);
      cycles++;
      if (i < 7) begin
        drive(~bm.ser_i, 1'b0, 1'b1);
        cycles++;
      end
      if (i < 7 && bm.par_valid) cycles = 100;
    end
    total++;
    if (cycles != 15 || bm.par_valid !== 1'b1) begin
      bad++;
      $display("FAIL gap_latency: got %0d cycles v=%b, expected 15 v=1", cycles, bm.par_valid);
    end
    total++;
    if (fe_cnt != fe0) begin
      bad++;
      $display("FAIL gap_frame_err: got %0d pulses, expected 0", fe_cnt - fe0);
    end
    drive(1'b0, 1'b0, 1'b0);
    check_queues("gaps");
  endtask

  task automatic test_overrun();
    int ov0 = ov_cnt;
    bm.par_ready = 1'b0;
    send_word(8'hA6, 1'b1, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    total++;
    if (ov_cnt - ov0 != 1) begin
      bad++;
      $display("FAIL overrun_cnt: got %0d, expected 1", ov_cnt - ov0);
    end
    total++;
    if (bm.par_valid !== 1'b1 || bm.par_data !== 8'hA6) begin
      bad++;
      $display("FAIL overrun_hold: got v=%b d=%h, expected v=1 d=a6", bm.par_valid, bm.par_data);
    end
    bm.par_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    total++;
    if (bm.par_valid !== 1'b0 || bm.par_data !== 8'hA6) begin
      bad++;
      $display("FAIL overrun_release: got v=%b d=%h, expected v=0 d=a6",
               bm.par_valid, bm.par_data);
    end
    check_queues("overrun");
  endtask

  task automatic test_frame_err();
    int fe0;
    bm.par_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    fe0 = fe_cnt;
    drive(1'b1, 1'b1, 1'b1);
    total++;
    if (bm.frame_err !== 1'b1 || bm.busy !== 1'b1) begin
      bad++;
      $display("FAIL frame_err_pulse: got fe=%b busy=%b, expected 1/1", bm.frame_err, bm.busy);
    end
    for (int i = 1; i < 8; i++) begin
      if (i == 7) expect_word(8'hF0);
      drive(bit'(8'hF0 >> (7 - i)), 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    total++;
    if (fe_cnt - fe0 != 1) begin
      bad++;
      $display("FAIL frame_err_cnt: got %0d, expected 1", fe_cnt - fe0);
    end
    check_queues("frame_err");
  endtask

  task automatic test_sof_at_last();
    int fe0 = fe_cnt;
    bm.par_ready = 1'b1;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, i == 0);
    send_word(8'h5A, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    total++;
    if (fe_cnt - fe0 != 1) begin
      bad++;
      $display("FAIL sof_last_fe: got %0d, expected 1", fe_cnt - fe0);
    end
    check_queues("sof_at_last");
  endtask

  task automatic test_back_to_back();
    bm.par_ready = 1'b1;
    send_word(8'hC3, 1'b1, 1'b0);
    send_word(8'h17, 1'b1, 1'b0);
    send_word(8'hFF, 1'b1, 1'b0);
    total++;
    if (bm.par_valid !== 1'b1 || bm.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: got v=%b busy=%b, expected 1/0", bm.par_valid, bm.busy);
    end
    drive(1'b0, 1'b0, 1'b0);
    check_queues("back_to_back");
  endtask

  task automatic test_async_reset();
    bm.par_ready = 1'b0;
    send_word(8'hA6, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(bit'(8'h3C >> (7 - i)), 1'b1, i == 0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bm.par_valid, bm.busy, bm.frame_err, bm.overrun} !== 4'b0 || bm.par_data !== 8'h00
        || bl.par_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got v=%b busy=%b d=%h, expected 0/0/00",
               bm.par_valid, bm.busy, bm.par_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) drive(i[0], 1'b1, 1'b0);
    total++;
    if (bm.busy !== 1'b0 || bm.par_valid !== 1'b0) begin
      bad++;
      $display("FAIL unframed: got busy=%b v=%b, expected 0/0", bm.busy, bm.par_valid);
    end
    bm.par_ready = 1'b1;
    send_word(8'h81, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_queues("async_reset");
  endtask

  initial begin
    test_reset();
    test_msb_lsb();
    test_gaps();
    test_overrun();
    test_frame_err();
    test_sof_at_last();
    test_back_to_back();
    test_async_reset();
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
